// File: rtl/promedio_pkg.sv
// promedio_pkg: shared types and helpers for the power-of-two sample averager.
// Holds the FSM state encoding, the log2 window clamp, and the accumulator
// width derivation used by promedio_pot2 and promedio_sat.
package promedio_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_t;

  // The accumulator holds up to 2^max_log2 full-scale samples without overflow.
  function automatic int acc_width(input int in_w, input int max_log2);
    return in_w + max_log2;
  endfunction

  // A requested window exponent above the supported maximum selects the maximum.
  function automatic int clamp_log2(input int log2_n, input int max_log2);
    return (log2_n > max_log2) ? max_log2 : log2_n;
  endfunction

  localparam int DEF_IN_W     = 16;
  localparam int DEF_MAX_LOG2 = 4;
  localparam int DEF_ACC_W    = acc_width(DEF_IN_W, DEF_MAX_LOG2);

endpackage

// File: rtl/promedio_sat.sv
// promedio_sat: combinational divide-by-2^k and saturate, ACC_W -> OUT_W.
// Build option: define PROMEDIO_ROUND_EN to round half up instead of floor.
module promedio_sat #(
  parameter int ACC_W  = 20,
  parameter int OUT_W  = 8,
  parameter int LOG2_W = 3
) (
  input  logic [ACC_W-1:0]  acc,
  input  logic [LOG2_W-1:0] k,
  output logic [OUT_W-1:0]  res,
  output logic              sat
);

`ifdef PROMEDIO_ROUND_EN
  localparam int SH_W = ACC_W + 1;

  logic [SH_W-1:0] sum;
  logic [SH_W-1:0] shifted;

  // Add half an LSB of the result before shifting; the extra bit keeps the carry.
  always_comb begin
    sum = {1'b0, acc};
    if (k != '0) begin
      sum = sum + (SH_W'(1) << (k - 1'b1));
    end
    shifted = sum >> k;
  end
`else
  localparam int SH_W = ACC_W;

  logic [SH_W-1:0] shifted;

  // Plain floor division by the window length.
  always_comb begin
    shifted = acc >> k;
  end
`endif

  localparam logic [SH_W-1:0] MAX_OUT = SH_W'({OUT_W{1'b1}});

  // Clamp to the largest representable output and flag it.
  always_comb begin
    if (shifted > MAX_OUT) begin
      res = {OUT_W{1'b1}};
      sat = 1'b1;
    end else begin
      res = shifted[OUT_W-1:0];
      sat = 1'b0;
    end
  end

endmodule

// File: rtl/promedio_pot2.sv
// promedio_pot2: averages 2^log2_n ring-oscillator count samples per window,
// running back-to-back windows while enabled.
// Build option: PROMEDIO_ROUND_EN (round half up in promedio_sat).
module promedio_pot2
  import promedio_pkg::*;
#(
  parameter int IN_W     = 16,
  parameter int OUT_W    = 8,
  parameter int MAX_LOG2 = 4,
  parameter int LOG2_W   = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic [LOG2_W-1:0] log2_n,
  input  logic              in_valid,
  input  logic [IN_W-1:0]   in,
  output logic [OUT_W-1:0]  out,
  output logic              out_valid,
  output logic              busy,
  output logic              overrun,
  output logic              sat
);

  localparam int ACC_W = acc_width(IN_W, MAX_LOG2);
  localparam int CNT_W = MAX_LOG2 + 1;

  state_t             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [LOG2_W-1:0]  k_q, k_d;
  logic [OUT_W-1:0]   out_q, out_d;
  logic               sat_q, sat_d;
  logic               out_valid_q, out_valid_d;
  logic               overrun_q, overrun_d;

  logic [LOG2_W-1:0]  k_sel;
  logic               last_sample;
  logic [OUT_W-1:0]   res;
  logic               res_sat;

  assign k_sel       = LOG2_W'(clamp_log2(int'(log2_n), MAX_LOG2));
  assign last_sample = (cnt_q == CNT_W'((1 << k_q) - 1));

  promedio_sat #(
    .ACC_W  (ACC_W),
    .OUT_W  (OUT_W),
    .LOG2_W (LOG2_W)
  ) u_sat (
    .acc (acc_q),
    .k   (k_q),
    .res (res),
    .sat (res_sat)
  );

  // Window sequencing: accumulate in ACC, publish the result on leaving DONE.
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    k_d         = k_q;
    out_d       = out_q;
    sat_d       = sat_q;
    out_valid_d = 1'b0;
    overrun_d   = overrun_q;
    case (state_q)
      IDLE: begin
        if (en) begin
          state_d = ACC;
          k_d     = k_sel;
          acc_d   = '0;
          cnt_d   = '0;
        end
      end
      ACC: begin
        if (!en) begin
          state_d = IDLE;
          acc_d   = '0;
          cnt_d   = '0;
        end else if (in_valid) begin
          acc_d = acc_q + ACC_W'(in);
          cnt_d = cnt_q + 1'b1;
          if (last_sample) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        if (in_valid) begin
          overrun_d = 1'b1;
        end
        acc_d = '0;
        cnt_d = '0;
        if (!en) begin
          state_d = IDLE;
        end else begin
          state_d     = ACC;
          k_d         = k_sel;
          out_d       = res;
          sat_d       = res_sat;
          out_valid_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        acc_d   = '0;
        cnt_d   = '0;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      k_q         <= '0;
      out_q       <= '0;
      sat_q       <= 1'b0;
      out_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      k_q         <= k_d;
      out_q       <= out_d;
      sat_q       <= sat_d;
      out_valid_q <= out_valid_d;
      overrun_q   <= overrun_d;
    end
  end

  assign out       = out_q;
  assign sat       = sat_q;
  assign out_valid = out_valid_q;
  assign overrun   = overrun_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_promedio_pot2.sv
// tb_promedio_pot2: directed self-checking bench for promedio_pot2.
// Expected values are hand-computed; PROMEDIO_ROUND_EN selects rounded ones.
module tb_promedio_pot2;

  logic        clk;
  logic        reset;
  logic        en;
  logic [2:0]  log2_n;
  logic        in_valid;
  logic [15:0] in_data;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        busy;
  logic        overrun;
  logic        sat;

  int n_compared;
  int n_mismatched;

`ifdef PROMEDIO_ROUND_EN
  localparam int EXP_GAPPED = 4;
`else
  localparam int EXP_GAPPED = 3;
`endif

  promedio_pot2 #(
    .IN_W     (16),
    .OUT_W    (8),
    .MAX_LOG2 (4),
    .LOG2_W   (3)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .log2_n    (log2_n),
    .in_valid  (in_valid),
    .in        (in_data),
    .out       (out_data),
    .out_valid (out_valid),
    .busy      (busy),
    .overrun   (overrun),
    .sat       (sat)
  );

  // Free-running 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance one edge and settle just after it; inputs change here too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset    = 1'b1;
    en       = 1'b1;
    log2_n   = 3'd0;
    in_valid = 1'b1;
    in_data  = 16'd500;
    tick();
    tick();
    n_compared++; if (out_data !== 8'd0) begin n_mismatched++; $display("[TB] FAIL rst_out: got %0d want 0", out_data); end
    n_compared++; if (out_valid !== 1'b0) begin n_mismatched++; $display("[TB] FAIL rst_out_valid: got %b want 0", out_valid); end
    n_compared++; if (busy !== 1'b0) begin n_mismatched++; $display("[TB] FAIL rst_busy: got %b want 0", busy); end
    n_compared++; if (overrun !== 1'b0) begin n_mismatched++; $display("[TB] FAIL rst_overrun: got %b want 0", overrun); end
    n_compared++; if (sat !== 1'b0) begin n_mismatched++; $display("[TB] FAIL rst_sat: got %b want 0", sat); end
    reset    = 1'b0;
    en       = 1'b0;
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_basic_average();
    logic [15:0] samples [4];
    samples = '{16'd10, 16'd20, 16'd30, 16'd40};
    log2_n = 3'd2;
    en     = 1'b1;
    tick();
    n_compared++; if (busy !== 1'b1) begin n_mismatched++; $display("[TB] FAIL basic_busy: got %b want 1", busy); end
    for (int i = 0; i < 4; i++) begin
      in_data  = samples[i];
      in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    // The edge after the last sample moves to DONE; no pulse yet.
    n_compared++; if (out_valid !== 1'b0) begin n_mismatched++; $display("[TB] FAIL basic_early_pulse: got %b want 0", out_valid); end
    tick();
    n_compared++; if (out_valid !== 1'b1) begin n_mismatched++; $display("[TB] FAIL basic_pulse: got %b want 1", out_valid); end
    n_compared++; if (out_data !== 8'd25) begin n_mismatched++; $display("[TB] FAIL basic_out: got %0d want 25", out_data); end
    n_compared++; if (sat !== 1'b0) begin n_mismatched++; $display("[TB] FAIL basic_sat: got %b want 0", sat); end
    tick();
    n_compared++; if (out_valid !== 1'b0) begin n_mismatched++; $display("[TB] FAIL basic_pulse_len: got %b want 0", out_valid); end
    n_compared++; if (out_data !== 8'd25) begin n_mismatched++; $display("[TB] FAIL basic_hold: got %0d want 25", out_data); end
    en = 1'b0;
    tick();
    n_compared++; if (busy !== 1'b0) begin n_mismatched++; $display("[TB] FAIL basic_idle_busy: got %b want 0", busy); end
  endtask

  task automatic test_saturation();
    log2_n = 3'd3;
    en     = 1'b1;
    tick();
    for (int i = 0; i < 8; i++) begin
      in_data  = 16'd1000;
      in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    tick();
    n_compared++; if (out_valid !== 1'b1) begin n_mismatched++; $display("[TB] FAIL sat_pulse: got %b want 1", out_valid); end
    n_compared++; if (out_data !== 8'd255) begin n_mismatched++; $display("[TB] FAIL sat_out: got %0d want 255", out_data); end
    n_compared++; if (sat !== 1'b1) begin n_mismatched++; $display("[TB] FAIL sat_flag: got %b want 1", sat); end
    for (int i = 0; i < 8; i++) begin
      in_data  = 16'd7;
      in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    tick();
    n_compared++; if (out_valid !== 1'b1) begin n_mismatched++; $display("[TB] FAIL small_pulse: got %b want 1", out_valid); end
    n_compared++; if (out_data !== 8'd7) begin n_mismatched++; $display("[TB] FAIL small_out: got %0d want 7", out_data); end
    n_compared++; if (sat !== 1'b0) begin n_mismatched++; $display("[TB] FAIL small_sat: got %b want 0", sat); end
    en = 1'b0;
    tick();
  endtask

  task automatic test_floor_round();
    int pulses;
    pulses = 0;
    log2_n = 3'd1;
    en     = 1'b1;
    tick();
    in_data  = 16'd3;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (out_valid === 1'b1) pulses++;
    end
    in_data  = 16'd4;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    n_compared++; if (pulses !== 0) begin n_mismatched++; $display("[TB] FAIL gap_pulses: got %0d want 0", pulses); end
    tick();
    n_compared++; if (out_valid !== 1'b1) begin n_mismatched++; $display("[TB] FAIL gap_pulse: got %b want 1", out_valid); end
    n_compared++; if (out_data !== 8'(EXP_GAPPED)) begin n_mismatched++; $display("[TB] FAIL gap_out: got %0d want %0d", out_data, EXP_GAPPED); end
    en = 1'b0;
    tick();
  endtask

  task automatic test_abort();
    int pulses;
    pulses   = 0;
    log2_n   = 3'd2;
    en       = 1'b1;
    tick();
    in_data  = 16'd5;
    in_valid = 1'b1;
    tick();
    in_data  = 16'd6;
    tick();
    in_valid = 1'b0;
    en       = 1'b0;
    tick();
    n_compared++; if (busy !== 1'b0) begin n_mismatched++; $display("[TB] FAIL abort_busy: got %b want 0", busy); end
    n_compared++; if (out_data !== 8'(EXP_GAPPED)) begin n_mismatched++; $display("[TB] FAIL abort_hold: got %0d want %0d", out_data, EXP_GAPPED); end
    for (int i = 0; i < 3; i++) begin
      tick();
      if (out_valid === 1'b1) pulses++;
    end
    n_compared++; if (pulses !== 0) begin n_mismatched++; $display("[TB] FAIL abort_pulses: got %0d want 0", pulses); end
    en = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      in_data  = 16'd8;
      in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    n_compared++; if (out_data !== 8'(EXP_GAPPED)) begin n_mismatched++; $display("[TB] FAIL abort_prev_hold: got %0d want %0d", out_data, EXP_GAPPED); end
    tick();
    n_compared++; if (out_valid !== 1'b1) begin n_mismatched++; $display("[TB] FAIL abort_pulse: got %b want 1", out_valid); end
    n_compared++; if (out_data !== 8'd8) begin n_mismatched++; $display("[TB] FAIL abort_out: got %0d want 8", out_data); end
    en = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back();
    // Edges 3 and 6 land in DONE; their samples (99, 77) must be dropped.
    logic [15:0] vals     [6];
    logic        exp_ov   [6];
    logic [7:0]  exp_out  [6];
    vals    = '{16'd10, 16'd20, 16'd99, 16'd30, 16'd50, 16'd77};
    exp_ov  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    exp_out = '{8'd8, 8'd8, 8'd15, 8'd15, 8'd15, 8'd40};
    n_compared++; if (overrun !== 1'b0) begin n_mismatched++; $display("[TB] FAIL b2b_overrun_pre: got %b want 0", overrun); end
    log2_n = 3'd1;
    en     = 1'b1;
    tick();
    in_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      in_data = vals[i];
      tick();
      n_compared++; if (out_valid !== exp_ov[i]) begin n_mismatched++; $display("[TB] FAIL b2b_pulse[%0d]: got %b want %b", i, out_valid, exp_ov[i]); end
      n_compared++; if (out_data !== exp_out[i]) begin n_mismatched++; $display("[TB] FAIL b2b_out[%0d]: got %0d want %0d", i, out_data, exp_out[i]); end
    end
    n_compared++; if (overrun !== 1'b1) begin n_mismatched++; $display("[TB] FAIL b2b_overrun: got %b want 1", overrun); end
    in_valid = 1'b0;
    en       = 1'b0;
    tick();
    tick();
    n_compared++; if (overrun !== 1'b1) begin n_mismatched++; $display("[TB] FAIL b2b_overrun_sticky: got %b want 1", overrun); end
  endtask

  task automatic test_clamp_and_reset_mid();
    int pulses;
    pulses = 0;
    log2_n = 3'd7;
    en     = 1'b1;
    tick();
    in_valid = 1'b1;
    in_data  = 16'd100;
    for (int i = 0; i < 16; i++) begin
      tick();
      if (out_valid === 1'b1) pulses++;
    end
    in_valid = 1'b0;
    n_compared++; if (pulses !== 0) begin n_mismatched++; $display("[TB] FAIL clamp_early_pulses: got %0d want 0", pulses); end
    tick();
    n_compared++; if (out_valid !== 1'b1) begin n_mismatched++; $display("[TB] FAIL clamp_pulse: got %b want 1", out_valid); end
    n_compared++; if (out_data !== 8'd100) begin n_mismatched++; $display("[TB] FAIL clamp_out: got %0d want 100", out_data); end
    in_valid = 1'b1;
    in_data  = 16'd200;
    for (int i = 0; i < 5; i++) tick();
    in_valid = 1'b0;
    reset    = 1'b1;
    tick();
    n_compared++; if (out_data !== 8'd0) begin n_mismatched++; $display("[TB] FAIL mid_rst_out: got %0d want 0", out_data); end
    n_compared++; if (out_valid !== 1'b0) begin n_mismatched++; $display("[TB] FAIL mid_rst_pulse: got %b want 0", out_valid); end
    n_compared++; if (busy !== 1'b0) begin n_mismatched++; $display("[TB] FAIL mid_rst_busy: got %b want 0", busy); end
    n_compared++; if (overrun !== 1'b0) begin n_mismatched++; $display("[TB] FAIL mid_rst_overrun: got %b want 0", overrun); end
    n_compared++; if (sat !== 1'b0) begin n_mismatched++; $display("[TB] FAIL mid_rst_sat: got %b want 0", sat); end
    reset = 1'b0;
    en    = 1'b0;
    tick();
  endtask

  // Run every scenario in order, then report.
  initial begin
    n_compared   = 0;
    n_mismatched = 0;
    reset        = 1'b1;
    en           = 1'b0;
    log2_n       = 3'd0;
    in_valid     = 1'b0;
    in_data      = 16'd0;
    test_reset();
    test_basic_average();
    test_saturation();
    test_floor_round();
    test_abort();
    test_back_to_back();
    test_clamp_and_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
